// File: rtl/layer_mem_arbiter_pkg.sv
// Shared constants and types for the layer-memory arbiter.
// Optional burst-lock arbitration is enabled by defining ARB_LOCK_EN.
package layer_mem_arbiter_pkg;

  localparam int LM_NUM_REQ  = 3;
  localparam int LM_AW       = 12;
  localparam int LM_DW       = 20;
  localparam int LM_SW       = 3;
  localparam int LM_LOCK_MAX = 4;

  localparam int REQ_CONV = 0;
  localparam int REQ_POOL = 1;
  localparam int REQ_HOST = 2;

  localparam logic [LM_SW-1:0] CSEL_NONE = 3'd0;
  localparam logic [LM_SW-1:0] CSEL_L0   = 3'd1;
  localparam logic [LM_SW-1:0] CSEL_L1   = 3'd3;

  typedef struct packed {
    logic             we;
    logic [LM_SW-1:0] sel;
    logic [LM_AW-1:0] addr;
    logic [LM_DW-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/layer_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant for the first set request
// found scanning from ptr upward with wrap-around.
module layer_mem_arbiter_rr_picker #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW:0] sum_s;
  logic [PW:0] idx_s;
  logic        found_s;

  // scan N positions starting at ptr and grant the first requester seen
  always_comb begin
    grant   = {N{1'b0}};
    found_s = 1'b0;
    sum_s   = {(PW+1){1'b0}};
    idx_s   = {(PW+1){1'b0}};
    for (int k = 0; k < N; k++) begin
      sum_s = {1'b0, ptr} + (PW+1)'(k);
      idx_s = (sum_s >= (PW+1)'(N)) ? (sum_s - (PW+1)'(N)) : sum_s;
      if (!found_s && req[idx_s[PW-1:0]]) begin
        grant[idx_s[PW-1:0]] = 1'b1;
        found_s              = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/layer_mem_arbiter.sv
// Round-robin arbiter sharing one layer-memory port among NUM_REQ engines.
// Define ARB_LOCK_EN to let a locked holder keep priority for LOCK_MAX grants.
module layer_mem_arbiter
  import layer_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = LM_NUM_REQ,
  parameter int AW       = LM_AW,
  parameter int DW       = LM_DW,
  parameter int SW       = LM_SW,
  parameter int LOCK_MAX = LM_LOCK_MAX
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*SW-1:0] req_sel,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]    req_lock,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic                  busy,
  output logic [SW-1:0]         csel,
  output logic                  cwr,
  output logic [AW-1:0]         caddr_wr,
  output logic [DW-1:0]         cdata_wr,
  output logic                  crd,
  output logic [AW-1:0]         caddr_rd,
  input  logic [DW-1:0]         cdata_rd
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] grant_s;
  logic               accept_s;
  logic [PW-1:0]      gidx_s;
  logic [PW-1:0]      ptr_r;
  logic [PW-1:0]      ptr_inc_s;
  logic [PW-1:0]      ptr_nxt_s;
  mem_cmd_t           cmd_s;

  logic [SW-1:0]      csel_r;
  logic               cwr_r;
  logic               crd_r;
  logic [AW-1:0]      caddr_wr_r;
  logic [AW-1:0]      caddr_rd_r;
  logic [DW-1:0]      cdata_wr_r;
  logic [NUM_REQ-1:0] rd_tag_r;
  logic [NUM_REQ-1:0] rsp_valid_r;
  logic [DW-1:0]      rsp_data_r;
  logic               busy_r;

  layer_mem_arbiter_rr_picker #(.N(NUM_REQ), .PW(PW)) u_rr_picker (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (grant_s)
  );

  assign req_ready = grant_s;
  assign accept_s  = |grant_s;
  assign ptr_inc_s = (gidx_s == PW'(NUM_REQ - 1)) ? {PW{1'b0}} : (gidx_s + PW'(1));

  // encode the one-hot grant and mux the winner's command fields
  always_comb begin
    gidx_s = {PW{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      gidx_s = gidx_s | (grant_s[i] ? PW'(i) : {PW{1'b0}});
    end
    cmd_s.we    = req_we[gidx_s];
    cmd_s.sel   = req_sel[int'(gidx_s)*SW +: SW];
    cmd_s.addr  = req_addr[int'(gidx_s)*AW +: AW];
    cmd_s.wdata = req_wdata[int'(gidx_s)*DW +: DW];
  end

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [CW-1:0] lock_cnt_r;
  logic [CW-1:0] lock_cnt_nxt_s;
  logic [CW-1:0] lock_run_s;
  logic [PW-1:0] lock_own_r;

  // a locked holder keeps the pointer on itself until its run reaches LOCK_MAX
  always_comb begin
    ptr_nxt_s      = ptr_r;
    lock_cnt_nxt_s = lock_cnt_r;
    lock_run_s     = (gidx_s == lock_own_r) ? (lock_cnt_r + CW'(1)) : CW'(1);
    if (accept_s) begin
      if (req_lock[gidx_s] && (int'(lock_run_s) < LOCK_MAX)) begin
        ptr_nxt_s      = gidx_s;
        lock_cnt_nxt_s = lock_run_s;
      end else begin
        ptr_nxt_s      = ptr_inc_s;
        lock_cnt_nxt_s = CW'(0);
      end
    end else if (!req_valid[lock_own_r] || !req_lock[lock_own_r]) begin
      lock_cnt_nxt_s = CW'(0);
    end else begin
      lock_cnt_nxt_s = lock_cnt_r;
    end
  end

  // lock run length and owner of the last grant
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt_r <= CW'(0);
      lock_own_r <= {PW{1'b0}};
    end else begin
      lock_cnt_r <= lock_cnt_nxt_s;
      if (accept_s) begin
        lock_own_r <= gidx_s;
      end
    end
  end
`else
  localparam int unused_lock_max = LOCK_MAX;
  logic unused_lock_s;
  assign unused_lock_s = ^req_lock;

  // plain round-robin: advance past the winner only on acceptance
  always_comb begin
    if (accept_s) begin
      ptr_nxt_s = ptr_inc_s;
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end
`endif

  // command stage, read-return stage and pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r       <= {PW{1'b0}};
      csel_r      <= {SW{1'b0}};
      cwr_r       <= 1'b0;
      crd_r       <= 1'b0;
      caddr_wr_r  <= {AW{1'b0}};
      caddr_rd_r  <= {AW{1'b0}};
      cdata_wr_r  <= {DW{1'b0}};
      rd_tag_r    <= {NUM_REQ{1'b0}};
      rsp_valid_r <= {NUM_REQ{1'b0}};
      rsp_data_r  <= {DW{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      ptr_r       <= ptr_nxt_s;
      cwr_r       <= accept_s & cmd_s.we;
      crd_r       <= accept_s & ~cmd_s.we;
      caddr_wr_r  <= (accept_s & cmd_s.we)  ? cmd_s.addr  : {AW{1'b0}};
      caddr_rd_r  <= (accept_s & ~cmd_s.we) ? cmd_s.addr  : {AW{1'b0}};
      cdata_wr_r  <= (accept_s & cmd_s.we)  ? cmd_s.wdata : {DW{1'b0}};
      rd_tag_r    <= (accept_s & ~cmd_s.we) ? grant_s     : {NUM_REQ{1'b0}};
      rsp_valid_r <= crd_r ? rd_tag_r : {NUM_REQ{1'b0}};
      busy_r      <= accept_s | crd_r;
      // csel holds across idle cycles; read data is held until the next return
      if (accept_s) begin
        csel_r <= cmd_s.sel;
      end
      if (crd_r) begin
        rsp_data_r <= cdata_rd;
      end
    end
  end

  assign csel      = csel_r;
  assign cwr       = cwr_r;
  assign crd       = crd_r;
  assign caddr_wr  = caddr_wr_r;
  assign caddr_rd  = caddr_rd_r;
  assign cdata_wr  = cdata_wr_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign busy      = busy_r;

endmodule
